reg_cut_timeout: RTL
====================

REG_CUT_TIMEOUT -- requirements
Module: reg_cut_timeout

Interface
REQ-001 SHALL have parameter reg_req_t, default logic: regbus request struct with fields addr[31:0], write, wdata[31:0], wstrb[3:0] and valid.
REQ-002 SHALL have parameter reg_rsp_t, default logic: regbus response struct with fields rdata[31:0], error and ready.
REQ-003 SHALL have parameter TimeoutCycles, int unsigned, default 256: downstream wait limit in cycles; legal range 2..65535.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req_i, input, reg_req_t: upstream request, e.g. from the APB-to-regbus converter.
REQ-007 SHALL have port rsp_o, output, reg_rsp_t: upstream response.
REQ-008 SHALL have port req_o, output, reg_req_t: registered downstream request.
REQ-009 SHALL have port rsp_i, input, reg_rsp_t: downstream response.
REQ-010 SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-012 IDLE with req_i.valid=1 SHALL capture addr, write, wdata and wstrb into request registers and go to BUSY; IDLE with req_i.valid=0 SHALL remain in IDLE.
REQ-013 In BUSY, req_o.valid SHALL be 1 and req_o fields SHALL come only from the registers, with no combinational path from req_i.
REQ-014 BUSY with rsp_i.ready=1 SHALL capture rsp_i.rdata and rsp_i.error into response registers and go to RESP.
REQ-015 In RESP, rsp_o.ready SHALL be 1 for exactly one cycle, with registered rdata/error, then go to IDLE.
REQ-016 rsp_o.ready SHALL be 0 in IDLE and BUSY; rsp_o.rdata and rsp_o.error SHALL always reflect the response registers.
REQ-017 Minimum latency SHALL be: req_i.valid sampled in cycle 0, req_o.valid in cycle 1, rsp_o.ready in cycle 2 when rsp_i.ready is high in cycle 1.
REQ-018 req_i.valid in RESP SHALL be ignored; the upstream master holds valid until ready, so the request is accepted in the following IDLE cycle.
REQ-019 For write transactions, the response registers SHALL capture rdata unchanged, without special-casing.
REQ-020 rsp_i SHALL be ignored outside BUSY.
REQ-021 No path from rsp_i to rsp_o or from req_i to req_o SHALL exist, making this a full timing cut.

Reset
REQ-022 Asserting rst_ni=0 SHALL asynchronously force: state IDLE, all request and response registers '0, timeout counter 0, req_o.valid=0, rsp_o.ready=0, timeout_o=0.
REQ-023 Reset during BUSY SHALL abandon the transaction with no response issued.

Configuration
REQ-024 Macro REG_CUT_TIMEOUT_EN defined: in BUSY, a counter of width $clog2(TimeoutCycles+1) SHALL increment each cycle rsp_i.ready=0 and clear on entry to BUSY.
REQ-025 With REG_CUT_TIMEOUT_EN, when the counter reaches TimeoutCycles-1 and rsp_i.ready=0, the block SHALL go to RESP with error=1, rdata=32'hDEAD_BEEF, and pulse timeout_o.
REQ-026 With REG_CUT_TIMEOUT_EN, a cycle where rsp_i.ready=1 and the counter hits its limit SHALL complete normally, with real response and no timeout.
REQ-027 Without REG_CUT_TIMEOUT_EN: no counter; BUSY SHALL wait indefinitely; timeout_o SHALL be tied to 0.

Structure
REQ-028 Package reg_cut_pkg SHALL hold the state enum (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and constant TimeoutRdata=32'hDEAD_BEEF.
REQ-029 Sub-module reg_cut_timer (counter plus expiry flag) SHALL exist, instantiated only under REG_CUT_TIMEOUT_EN.

Verification
REQ-030 Read test: req_i read addr 0x10; downstream ready in cycle 1 with rdata 0xCAFE0001 -> rsp_o.ready in cycle 2 with rdata 0xCAFE0001 and error=0.
REQ-031 Write test: addr 0x20, wdata 0x12345678, wstrb 0xF; downstream ready after 5 cycles -> req_o fields stable throughout BUSY; rsp_o.ready one cycle after ready.
REQ-032 Error passthrough: downstream returns error=1 -> rsp_o.error=1 for the one-cycle ready.
REQ-033 Timeout (macro on, TimeoutCycles=4): downstream never ready -> req_o.valid high for exactly 4 cycles, then rsp_o.error=1, rdata 0xDEADBEEF, timeout_o pulses once.
REQ-034 Boundary (macro on): downstream ready exactly on the 4th BUSY cycle -> normal response; timeout_o stays 0.
REQ-035 Reset in BUSY: rst_ni low mid-transaction -> req_o.valid and rsp_o.ready drop immediately; the next request completes normally.

Source files
------------

// File: rtl/reg_cut_pkg.sv
// ============================================================================
//  Module   : reg_cut_pkg
//  Purpose  : Shared types and constants for the regbus register cut with
//             optional downstream timeout (REG_CUT_TIMEOUT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_cut_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Read data returned on a transaction aborted by timeout.
  localparam logic [31:0] TimeoutRdata = 32'hDEAD_BEEF;

  // Regbus request.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  // Regbus response.
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

`default_nettype wire

// File: rtl/reg_cut_timer.sv
// ============================================================================
//  Module   : reg_cut_timer
//  Purpose  : Downstream wait counter with expiry flag. Used only when
//             REG_CUT_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_cut_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count waiting cycles; cleared whenever no transaction is outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && (r_count != c_limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/reg_cut_timeout.sv
// ============================================================================
//  Module   : reg_cut_timeout
//  Purpose  : Full timing cut for a regbus link. The request is registered,
//             forwarded downstream, and the response is registered before
//             being returned upstream. Define REG_CUT_TIMEOUT_EN to abort
//             transactions the downstream side does not answer in time.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_cut_timeout
  import reg_cut_pkg::*;
#(
  // Defaults are the package regbus structs so the block elaborates standalone.
  parameter type         reg_req_t     = reg_cut_pkg::reg_req_t,
  parameter type         reg_rsp_t     = reg_cut_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t req_i,
  output reg_rsp_t rsp_o,
  output reg_req_t req_o,
  input  reg_rsp_t rsp_i,
  output logic     timeout_o
);

  state_e      r_state;
  state_e      w_state_next;

  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_error;

  logic        w_accept;
  logic        w_done;
  logic        w_expire;

`ifdef REG_CUT_TIMEOUT_EN
  logic w_timer_clear;
  logic w_timer_count;
  logic w_timer_expired;
  logic r_timeout;

  assign w_timer_clear = (r_state != BUSY);
  assign w_timer_count = (r_state == BUSY) && !rsp_i.ready;

  reg_cut_timer #(
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_clear   (w_timer_clear),
    .i_count   (w_timer_count),
    .o_expired (w_timer_expired)
  );

  // A real response arriving on the limit cycle wins over the timeout.
  assign w_expire = (r_state == BUSY) && w_timer_expired && !rsp_i.ready;

  // One-cycle pulse coinciding with the aborted response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_cfg;

  assign w_expire     = 1'b0;
  assign timeout_o    = 1'b0;
  assign w_unused_cfg = (TimeoutCycles < 32'd2);
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and register load enables.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i.valid) begin
          w_accept     = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (rsp_i.ready || w_expire) begin
          w_done       = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Request and response capture registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_i.addr;
        r_write <= req_i.write;
        r_wdata <= req_i.wdata;
        r_wstrb <= req_i.wstrb;
      end
      if (w_done) begin
        r_rdata <= w_expire ? TimeoutRdata : rsp_i.rdata;
        r_error <= w_expire | rsp_i.error;
      end
    end
  end

  // Outputs driven purely from registered state.
  always_comb begin
    req_o       = '0;
    req_o.addr  = r_addr;
    req_o.write = r_write;
    req_o.wdata = r_wdata;
    req_o.wstrb = r_wstrb;
    req_o.valid = (r_state == BUSY);

    rsp_o       = '0;
    rsp_o.rdata = r_rdata;
    rsp_o.error = r_error;
    rsp_o.ready = (r_state == RESP);
  end

endmodule

`default_nettype wire
